ddr4_lanectrl_delay_seq: RTL and testbench

//  Sequencer for the DDR4 lane-controller delay lines (RX DQS / TX DQS). Accepts
//  one load-or-move command at a time from training logic and emits the

---
 rtl/ddr4_lanectrl_delay_seq_if.sv | 36 +++
 rtl/ddr4_lanectrl_delay_seq.sv | 195 +++++++++++++++++++
 tb/tb_ddr4_lanectrl_delay_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_lanectrl_delay_seq_if.sv
// ---------------------------------------------------------------------------
// ddr4_lanectrl_delay_seq_if
// Command/response bundle between the training logic (master) and the
// lane-controller delay-line sequencer (slave).
//   cmd_valid / cmd_ready   : command handshake
//   cmd_op                  : 0 = load (return line to init), 1 = move
//   cmd_sel                 : 0 = RX DQS line, 1 = TX DQS line
//   cmd_dir                 : move direction, 1 = increase delay
//   cmd_taps                : number of move steps (ignored for load)
//   resp_valid              : one-cycle completion pulse
//   resp_oor                : move aborted on out-of-range
//   resp_done_taps          : steps actually applied
// ---------------------------------------------------------------------------
interface ddr4_lanectrl_delay_seq_if #(
  parameter int TAP_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic             cmd_sel;
  logic             cmd_dir;
  logic [TAP_W-1:0] cmd_taps;
  logic             resp_valid;
  logic             resp_oor;
  logic [TAP_W-1:0] resp_done_taps;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_dir, cmd_taps,
    input  cmd_ready, resp_valid, resp_oor, resp_done_taps
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_dir, cmd_taps,
    output cmd_ready, resp_valid, resp_oor, resp_done_taps
  );
endinterface

// File: rtl/ddr4_lanectrl_delay_seq.sv
// ---------------------------------------------------------------------------
// ddr4_lanectrl_delay_seq
// Sequences load/move commands onto the DDR4 lane-controller RX/TX DQS delay
// lines. Every adjustment is wrapped in an HS_IO_CLK_PAUSE window, the tap
// position of each line is tracked, and moves abort on out-of-range.
// Ports:
//   fab_clk_i                     fabric clock (only clock)
//   reset_i                       synchronous active-high reset
//   cmd_if (slave)                command / response bundle
//   tap_pos_rx_o, tap_pos_tx_o    tracked tap position per line
//   delay_line_sel_o              line select, held for the whole command
//   delay_line_load_o             one-cycle load strobe
//   delay_line_direction_o        move direction, held for the whole command
//   delay_line_move_o             one-cycle strobe per step
//   hs_io_clk_pause_o             pause request to lane-ctrl synchroniser
//   rx/tx_delay_line_out_of_range_i  out-of-range flags from lane ctrl
// ---------------------------------------------------------------------------
module ddr4_lanectrl_delay_seq #(
  parameter int TAP_W       = 8,
  parameter int PAUSE_SETUP = 4,
  parameter int MOVE_GAP    = 3,
  parameter int PAUSE_HOLD  = 4
) (
  input  logic             fab_clk_i,
  input  logic             reset_i,
  ddr4_lanectrl_delay_seq_if.slave cmd_if,
  output logic [TAP_W-1:0] tap_pos_rx_o,
  output logic [TAP_W-1:0] tap_pos_tx_o,
  output logic             delay_line_sel_o,
  output logic             delay_line_load_o,
  output logic             delay_line_direction_o,
  output logic             delay_line_move_o,
  output logic             hs_io_clk_pause_o,
  input  logic             rx_delay_line_out_of_range_i,
  input  logic             tx_delay_line_out_of_range_i
);

  // One shared wait counter serves PAUSE_ON, GAP and PAUSE_OFF.
  localparam int CNT_MAX_A = (PAUSE_SETUP > MOVE_GAP) ? PAUSE_SETUP : MOVE_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > PAUSE_HOLD) ? CNT_MAX_A : PAUSE_HOLD;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(PAUSE_SETUP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MOVE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(PAUSE_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE_ON, S_LOAD, S_MOVE, S_GAP, S_PAUSE_OFF, S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             sel_q, sel_d;
  logic             dir_q, dir_d;
  logic [TAP_W-1:0] taps_q, taps_d;
  logic [TAP_W-1:0] done_q, done_d;
  logic             oor_q, oor_d;
  logic             clr_pos;   // LOAD: return selected line to 0
  logic             step_pos;  // GAP end without OOR: step selected line
  logic             oor_sel;
  logic [TAP_W-1:0] done_inc;

  // Only the selected line's flag matters, and only on the GAP sample cycle.
  assign oor_sel  = sel_q ? tx_delay_line_out_of_range_i : rx_delay_line_out_of_range_i;
  assign done_inc = done_q + TAP_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    taps_d   = taps_q;
    done_d   = done_q;
    oor_d    = oor_q;
    clr_pos  = 1'b0;
    step_pos = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid) begin
          op_d    = cmd_if.cmd_op;
          sel_d   = cmd_if.cmd_sel;
          dir_d   = cmd_if.cmd_dir;
          taps_d  = cmd_if.cmd_taps;
          done_d  = '0;
          oor_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_PAUSE_ON;
        end
      end
      S_PAUSE_ON: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d = '0;
          if (!op_q)             state_d = S_LOAD;
          else if (taps_q != '0) state_d = S_MOVE;
          else                   state_d = S_PAUSE_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        clr_pos = 1'b1;
        cnt_d   = '0;
        state_d = S_PAUSE_OFF;
      end
      S_MOVE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (oor_sel) begin
            oor_d   = 1'b1;
            state_d = S_PAUSE_OFF;
          end else begin
            step_pos = 1'b1;
            done_d   = done_inc;
            state_d  = (done_inc < taps_q) ? S_MOVE : S_PAUSE_OFF;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAUSE_OFF: begin
        if (cnt_q == HOLD_LAST) state_d = S_RESP;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fab_clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      sel_q   <= 1'b0;
      dir_q   <= 1'b0;
      taps_q  <= '0;
      done_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      taps_q  <= taps_d;
      done_q  <= done_d;
      oor_q   <= oor_d;
    end
  end

  // Per-line tap trackers: line 0 = RX, line 1 = TX. Steps saturate at both ends.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [TAP_W-1:0] pos_q, pos_d;

    always_comb begin
      pos_d = pos_q;
      if (sel_q == 1'(gi)) begin
        if (clr_pos) begin
          pos_d = '0;
        end else if (step_pos) begin
          if (dir_q) pos_d = (pos_q == '1) ? pos_q : pos_q + TAP_W'(1);
          else       pos_d = (pos_q == '0) ? pos_q : pos_q - TAP_W'(1);
        end
      end
    end

    always_ff @(posedge fab_clk_i) begin
      if (reset_i) pos_q <= '0;
      else         pos_q <= pos_d;
    end
  end

  assign tap_pos_rx_o = g_line[0].pos_q;
  assign tap_pos_tx_o = g_line[1].pos_q;

  // Strobes and pause decode straight from the state register.
  logic busy;
  assign busy                   = (state_q != S_IDLE);
  assign cmd_if.cmd_ready       = (state_q == S_IDLE);
  assign hs_io_clk_pause_o      = (state_q == S_PAUSE_ON) || (state_q == S_LOAD) ||
                                  (state_q == S_MOVE) || (state_q == S_GAP);
  assign delay_line_load_o      = (state_q == S_LOAD);
  assign delay_line_move_o      = (state_q == S_MOVE);
  assign delay_line_sel_o       = busy & sel_q;
  assign delay_line_direction_o = busy & dir_q;
  assign cmd_if.resp_valid      = (state_q == S_RESP);
  assign cmd_if.resp_oor        = (state_q == S_RESP) & oor_q;
  assign cmd_if.resp_done_taps  = (state_q == S_RESP) ? done_q : '0;

endmodule

// File: tb/tb_ddr4_lanectrl_delay_seq.sv
module tb_ddr4_lanectrl_delay_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr4_lanectrl_delay_seq_if #(.TAP_W(8)) bus();

  logic [7:0] pos_rx, pos_tx;
  logic sel, load, dir, move, pause;
  logic rx_oor = 1'b0;
  logic tx_oor = 1'b0;

  ddr4_lanectrl_delay_seq dut (
    .fab_clk_i                    (clk),
    .reset_i                      (rst),
    .cmd_if                       (bus),
    .tap_pos_rx_o                 (pos_rx),
    .tap_pos_tx_o                 (pos_tx),
    .delay_line_sel_o             (sel),
    .delay_line_load_o            (load),
    .delay_line_direction_o       (dir),
    .delay_line_move_o            (move),
    .hs_io_clk_pause_o            (pause),
    .rx_delay_line_out_of_range_i (rx_oor),
    .tx_delay_line_out_of_range_i (tx_oor)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int         move_q[$];
  logic [1:0] move_sd[$];
  int         resp_q[$];
  int         load_cnt = 0, load_cyc = 0, pause_cnt = 0, resp_cnt = 0, conflict_cnt = 0;
  logic       resp_oor_s = 1'b0;
  logic [7:0] resp_done_s = 8'd0;

  always @(negedge clk) begin
    if (move) begin
      move_q.push_back(cyc);
      move_sd.push_back({sel, dir});
    end
    if (load) begin
      load_cnt++;
      load_cyc = cyc;
    end
    if (load && move) conflict_cnt++;
    if (pause) pause_cnt++;
    if (bus.resp_valid) begin
      resp_cnt++;
      resp_q.push_back(cyc);
      resp_oor_s  = bus.resp_oor;
      resp_done_s = bus.resp_done_taps;
      $display("txn resp cyc=%0d oor=%0b done_taps=%0d pos_rx=%0d pos_tx=%0d",
               cyc, bus.resp_oor, bus.resp_done_taps, pos_rx, pos_tx);
    end
  end

  int compared = 0;
  int failed   = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int mv(input int idx);
    return (idx < move_q.size()) ? move_q[idx] : -1000;
  endfunction

  task automatic issue(input bit op, input bit s, input bit d, input logic [7:0] taps, output int acc);
    bus.cmd_op = op; bus.cmd_sel = s; bus.cmd_dir = d; bus.cmd_taps = taps;
    bus.cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
      step();
    end
    step();
    bus.cmd_valid = 1'b0;
    $display("txn cmd op=%0b sel=%0b dir=%0b taps=%0d accepted cyc=%0d", op, s, d, taps, acc);
    compared++;
    if (acc < 0) begin failed++; $display("FAIL accept: got timeout expected accept"); end
  endtask

  task automatic wait_resp(input int start_cnt, input int budget);
    for (int i = 0; i < budget && resp_cnt <= start_cnt; i++) step();
    compared++;
    if (resp_cnt <= start_cnt) begin failed++; $display("FAIL resp_wait: got no RESP_VALID expected one"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    compared++;
    if (bus.cmd_ready !== 1'b1) begin failed++; $display("FAIL rst_ready: got %0b expected 1", bus.cmd_ready); end
    compared++;
    if ({pause, move, load, sel, dir, bus.resp_valid, bus.resp_oor} !== 7'b0) begin
      failed++; $display("FAIL rst_outs: got %b expected 0000000", {pause, move, load, sel, dir, bus.resp_valid, bus.resp_oor});
    end
    compared++;
    if ({pos_rx, pos_tx, bus.resp_done_taps} !== 24'd0) begin
      failed++; $display("FAIL rst_pos: got rx=%0d tx=%0d done=%0d expected 0", pos_rx, pos_tx, bus.resp_done_taps);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_move_tx();
    int acc, n0, p0, r0;
    n0 = move_q.size(); p0 = pause_cnt; r0 = resp_cnt;
    issue(1'b1, 1'b1, 1'b1, 8'd3, acc);
    wait_resp(r0, 60);
    compared++;
    if (move_q.size() - n0 != 3) begin failed++; $display("FAIL t1_pulses: got %0d expected 3", move_q.size() - n0); end
    compared++;
    if (mv(n0) - acc != 5) begin failed++; $display("FAIL t1_first_move: got %0d expected 5", mv(n0) - acc); end
    compared++;
    if (mv(n0 + 1) - mv(n0) != 4 || mv(n0 + 2) - mv(n0 + 1) != 4) begin
      failed++; $display("FAIL t1_spacing: got %0d,%0d expected 4,4", mv(n0 + 1) - mv(n0), mv(n0 + 2) - mv(n0 + 1));
    end
    compared++;
    if (move_sd.size() < n0 + 3 || move_sd[n0] !== 2'b11 || move_sd[n0 + 1] !== 2'b11 || move_sd[n0 + 2] !== 2'b11) begin
      failed++; $display("FAIL t1_sel_dir: got sel/dir not 11 on a pulse expected 11");
    end
    compared++;
    if (resp_q[r0] - acc != 21) begin failed++; $display("FAIL t1_latency: got %0d expected 21", resp_q[r0] - acc); end
    compared++;
    if (resp_oor_s !== 1'b0 || resp_done_s !== 8'd3) begin
      failed++; $display("FAIL t1_resp: got oor=%0b done=%0d expected oor=0 done=3", resp_oor_s, resp_done_s);
    end
    compared++;
    if (pos_tx !== 8'd3) begin failed++; $display("FAIL t1_pos_tx: got %0d expected 3", pos_tx); end
    compared++;
    if (pause_cnt - p0 != 16) begin failed++; $display("FAIL t1_pause_len: got %0d expected 16", pause_cnt - p0); end
  endtask

  task automatic test_oor_abort();
    int acc, n0, r0;
    n0 = move_q.size(); r0 = resp_cnt;
    issue(1'b1, 1'b0, 1'b1, 8'd5, acc);
    for (int i = 0; i < 40 && move_q.size() < n0 + 2; i++) step();
    rx_oor = 1'b1;
    wait_resp(r0, 60);
    rx_oor = 1'b0;
    compared++;
    if (move_q.size() - n0 != 2) begin failed++; $display("FAIL t2_pulses: got %0d expected 2", move_q.size() - n0); end
    compared++;
    if (resp_oor_s !== 1'b1 || resp_done_s !== 8'd1) begin
      failed++; $display("FAIL t2_resp: got oor=%0b done=%0d expected oor=1 done=1", resp_oor_s, resp_done_s);
    end
    compared++;
    if (pos_rx !== 8'd1 || pos_tx !== 8'd3) begin failed++; $display("FAIL t2_pos: got rx=%0d tx=%0d expected rx=1 tx=3", pos_rx, pos_tx); end
    compared++;
    if (resp_q[r0] - acc != 17) begin failed++; $display("FAIL t2_latency: got %0d expected 17", resp_q[r0] - acc); end
  endtask

  task automatic test_saturate();
    int acc, n0, r0;
    n0 = move_q.size(); r0 = resp_cnt;
    issue(1'b1, 1'b1, 1'b0, 8'd5, acc);
    wait_resp(r0, 80);
    compared++;
    if (move_q.size() - n0 != 5) begin failed++; $display("FAIL t3_pulses: got %0d expected 5", move_q.size() - n0); end
    compared++;
    if (resp_oor_s !== 1'b0 || resp_done_s !== 8'd5) begin
      failed++; $display("FAIL t3_resp: got oor=%0b done=%0d expected oor=0 done=5", resp_oor_s, resp_done_s);
    end
    compared++;
    if (pos_tx !== 8'd0) begin failed++; $display("FAIL t3_pos_tx: got %0d expected 0", pos_tx); end
    compared++;
    if (resp_q[r0] - acc != 29) begin failed++; $display("FAIL t3_latency: got %0d expected 29", resp_q[r0] - acc); end
  endtask

  task automatic test_load();
    int acc, n0, l0, r0;
    // Bring RX from 1 up to 7 first.
    r0 = resp_cnt;
    issue(1'b1, 1'b0, 1'b1, 8'd6, acc);
    wait_resp(r0, 80);
    compared++;
    if (pos_rx !== 8'd7 || resp_done_s !== 8'd6) begin
      failed++; $display("FAIL t4_setup: got pos_rx=%0d done=%0d expected 7,6", pos_rx, resp_done_s);
    end
    n0 = move_q.size(); l0 = load_cnt; r0 = resp_cnt;
    issue(1'b0, 1'b0, 1'b0, 8'd9, acc);
    wait_resp(r0, 40);
    compared++;
    if (load_cnt - l0 != 1 || move_q.size() != n0) begin
      failed++; $display("FAIL t4_strobes: got loads=%0d moves=%0d expected 1,0", load_cnt - l0, move_q.size() - n0);
    end
    compared++;
    if (load_cyc - acc != 5) begin failed++; $display("FAIL t4_load_time: got %0d expected 5", load_cyc - acc); end
    compared++;
    if (resp_q[r0] - acc != 10) begin failed++; $display("FAIL t4_latency: got %0d expected 10", resp_q[r0] - acc); end
    compared++;
    if (pos_rx !== 8'd0 || resp_done_s !== 8'd0 || resp_oor_s !== 1'b0) begin
      failed++; $display("FAIL t4_result: got pos_rx=%0d done=%0d oor=%0b expected 0,0,0", pos_rx, resp_done_s, resp_oor_s);
    end
  endtask

  task automatic test_back_to_back();
    int accs[$];
    int n0, l0, p0, r0;
    n0 = move_q.size(); l0 = load_cnt; p0 = pause_cnt; r0 = resp_cnt;
    bus.cmd_op = 1'b1; bus.cmd_sel = 1'b0; bus.cmd_dir = 1'b1; bus.cmd_taps = 8'd0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 60 && accs.size() < 2; i++) begin
      if (bus.cmd_ready) begin
        accs.push_back(cyc);
        $display("txn cmd op=1 taps=0 held-valid accepted cyc=%0d", cyc);
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    wait_resp(r0 + 1, 40);
    compared++;
    if (accs.size() != 2) begin failed++; $display("FAIL t5_accepts: got %0d expected 2", accs.size()); end
    compared++;
    if (resp_q[r0] - accs[0] != 9) begin failed++; $display("FAIL t5_latency: got %0d expected 9", resp_q[r0] - accs[0]); end
    compared++;
    if (accs.size() < 2 || accs[1] - resp_q[r0] != 1) begin failed++; $display("FAIL t5_reaccept: got gap %0d expected 1", (accs.size() < 2) ? -1 : accs[1] - resp_q[r0]); end
    compared++;
    if (move_q.size() != n0 || load_cnt != l0) begin failed++; $display("FAIL t5_strobes: got moves=%0d loads=%0d expected 0,0", move_q.size() - n0, load_cnt - l0); end
    compared++;
    if (pause_cnt - p0 != 8) begin failed++; $display("FAIL t5_pause_len: got %0d expected 8", pause_cnt - p0); end
  endtask

  task automatic test_reset_abort();
    int acc, n0, r0;
    n0 = move_q.size();
    issue(1'b1, 1'b1, 1'b1, 8'd4, acc);
    for (int i = 0; i < 40 && move_q.size() < n0 + 2; i++) step();
    step();  // now in the first cycle of the second GAP
    compared++;
    if (pos_tx !== 8'd1 || pause !== 1'b1) begin failed++; $display("FAIL t6_pre: got pos_tx=%0d pause=%0b expected 1,1", pos_tx, pause); end
    rst = 1'b1;
    step();
    r0 = resp_cnt;
    compared++;
    if (pause !== 1'b0 || bus.cmd_ready !== 1'b1) begin failed++; $display("FAIL t6_abort: got pause=%0b ready=%0b expected 0,1", pause, bus.cmd_ready); end
    compared++;
    if (pos_rx !== 8'd0 || pos_tx !== 8'd0) begin failed++; $display("FAIL t6_pos: got rx=%0d tx=%0d expected 0,0", pos_rx, pos_tx); end
    rst = 1'b0;
    repeat (30) step();
    compared++;
    if (resp_cnt != r0 || move_q.size() != n0 + 2) begin
      failed++; $display("FAIL t6_quiet: got resps=%0d moves=%0d expected 0,2", resp_cnt - r0, move_q.size() - n0);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_sel = 1'b0;
    bus.cmd_dir = 1'b0; bus.cmd_taps = 8'd0;
    test_reset();
    test_move_tx();
    test_oor_abort();
    test_saturate();
    test_load();
    test_back_to_back();
    test_reset_abort();
    compared++;
    if (conflict_cnt != 0) begin failed++; $display("FAIL load_move_overlap: got %0d expected 0", conflict_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
